dmem_sched: RTL and testbench
=============================

Name: dmem_sched

Overview:
- Two-requester scheduler in front of the data memory (dmem); a requester is either the CPU data port or a loader/debug port.
- Arbitrates, latches one transaction at a time and sequences the memory's separate read and write strobes.
- Stores use the two-step order the byte-enable memory needs: an old-word read strobe with we high, then a write strobe.
- Sits between rv32is/loader and dmem; generates dmem_rdclk/dmem_wrclk from flops, replacing direct clock wiring.

Parameters:
- ARB_MODE, 0, 0 = round-robin between m0/m1; 1 = fixed priority, m0 wins.
- ADDR_W, 32, address width forwarded to dmem.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- mN_req  in  1  request, N=0,1; held with payload until mN_gnt.
- mN_we  in  1  1 = store, 0 = load.
- mN_addr  in  ADDR_W  byte address.
- mN_wdata  in  32  store data.
- mN_memop  in  3  dmem memop encoding (lb/lh/lw/lbu/lhu, sb/sh/sw).
- mN_gnt  out  1  one-cycle pulse: request accepted, payload captured.
- mN_rvalid  out  1  one-cycle pulse: load data valid on mN_rdata.
- mN_rdata  out  32  load data.
- mN_wack  out  1  one-cycle pulse: store committed.
- busy  out  1  high whenever state != IDLE.
- dmem_addr  out  ADDR_W  latched address.
- dmem_datain  out  32  latched store data.
- dmem_memop  out  3  latched memop.
- dmem_we  out  1  latched we.
- dmem_rdclk  out  1  registered read strobe.
- dmem_wrclk  out  1  registered write strobe.
- dmem_dataout  in  32  dmem load result.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All outputs are 0, including the strobes, the dmem_* latches, busy and every pulse.
  - last_winner resets to 1, so m0 wins the first round-robin tie.
- FSM states and per-state actions:
  - IDLE: on the edge where any req is high, choose the winner, latch addr/wdata/memop/we into the dmem_* regs and go to ACCESS.
  - ACCESS: winner gnt=1 and dmem_rdclk=1 this cycle. Next state is WRITE if we=1, RESP if we=0.
  - RESP: winner rvalid=1; rdata = dmem_dataout, registered into a per-port rdata hold reg that stays valid until that port's next load. Next state IDLE.
  - WRITE: dmem_rdclk=0, dmem_wrclk=1, dmem_we held at 1. Next state DONE.
  - DONE: winner wack=1, dmem_wrclk=0. Next state IDLE.
- Latency, with req sampled at the edge ending cycle 0:
  - gnt in cycle 1.
  - Load: rvalid in cycle 2.
  - Store: wrclk in cycle 2, wack in cycle 3.
- Throughput: load 3 cycles, store 4 cycles, with no idle bubble beyond IDLE.
- Hold and re-request rules:
  - dmem_addr/datain/memop stay stable from ACCESS through the final state. They then hold their last value; no zeroing.
  - dmem_we is cleared when returning to IDLE.
  - A requester must drop req in the cycle after gnt, otherwise the request is taken as a new one.
- Arbitration:
  - ARB_MODE=0: single request wins. On a tie the port != last_winner wins; last_winner updates at grant.
  - ARB_MODE=1: m0 wins every tie; m1 may starve, which is accepted.
- Requests arriving while busy wait; they are never dropped.
- Out-of-range memop on a store (011, 1xx): forwarded unchanged. dmem masks all bytes, so memory is unchanged, but the full sequence still runs and wack still pulses.
- Strobes come only from flops, one clock-cycle high, never both high in the same cycle.
- Reset mid-operation:
  - Strobes drop immediately; no gnt/rvalid/wack for the aborted transaction.
  - If reset hits during WRITE, the word at that address is undefined.
  - After release the block accepts requests from IDLE normally.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE, ACCESS, RESP, WRITE, DONE);
  - memop constants MEMOP_B=000, MEMOP_H=001, MEMOP_W=010, MEMOP_BU=100, MEMOP_HU=101;
  - ARB_RR/ARB_FIXED constants.
- One sub-module, rr_arb2: a two-way picker taking req[1:0], last_winner and mode, and returning a one-hot winner.

Test Plan:
1. Hold reset low for 3 cycles, then release → all outputs 0, busy=0; a request in the first cycle after release gets gnt in the next cycle.
2. mem word 0x40 = 0xDEADBEEF; m0 lw addr 0x100 in cycle 0 → m0_gnt and dmem_rdclk in cycle 1, m0_rvalid with m0_rdata=0xDEADBEEF in cycle 2, busy low in cycle 3.
3. Word at 0x100 = 0x11223344; m1 sb addr 0x101 data 0xAB → wrclk in cycle 2, m1_wack in cycle 3; a following lw of 0x100 returns 0x1122AB44.
4. Both req held continuously, ARB_MODE=0 → grants alternate m0, m1, m0, m1. With ARB_MODE=1 → m0 granted every time, m1 never.
5. Word 0x8000FF80: lh addr 2 → 0xFFFF8000; lbu addr 0 → 0x00000080; lb addr 0 → 0xFFFFFF80.
6. Assert reset during WRITE → wrclk drops asynchronously, no wack; after release a new m0 lw completes with the 3-cycle latency.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem scheduler and its arbiter.
package dmem_pkg;

    // Scheduler sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        RESP   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // dmem memop encodings (stores reuse B/H/W)
    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    // Arbitration modes
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Port index to one-hot port vector
    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_sched_arb.sv
// Two-way request picker: round-robin on last winner, or fixed m0 priority.
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_winner,
    input  logic       i_mode,
    output logic [1:0] o_winner
);

    // Pick a one-hot winner; a tie goes to m0 in fixed mode, else to the port that did not win last
    always_comb begin
        o_winner = 2'b00;
        case (i_req)
            2'b01: o_winner = 2'b01;
            2'b10: o_winner = 2'b10;
            2'b11: begin
                if (i_mode) begin
                    o_winner = 2'b01;
                end else if (i_last_winner) begin
                    o_winner = 2'b01;
                end else begin
                    o_winner = 2'b10;
                end
            end
            default: o_winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_sched.sv
// Two-requester dmem scheduler: arbitrates, latches one transaction and
// sequences registered read/write strobes (stores: old-word read, then write).
module dmem_sched
    import dmem_pkg::*;
#(
    parameter int ARB_MODE = 0,
    parameter int ADDR_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [2:0]        m0_memop,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_wack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [2:0]        m1_memop,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_wack,
    output logic              busy,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_datain,
    output logic [2:0]        dmem_memop,
    output logic              dmem_we,
    output logic              dmem_rdclk,
    output logic              dmem_wrclk,
    input  logic [31:0]       dmem_dataout
);

    localparam logic L_MODE = (ARB_MODE == ARB_FIXED) ? 1'b1 : 1'b0;

    state_t            r_state;
    logic [1:0]        r_gnt;
    logic [1:0]        r_rvalid;
    logic [1:0]        r_wack;
    logic [31:0]       r_rdata0;
    logic [31:0]       r_rdata1;
    logic              r_busy;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_datain;
    logic [2:0]        r_memop;
    logic              r_we;
    logic              r_rdclk;
    logic              r_wrclk;
    logic              r_last_winner;
    logic              r_winner;

    logic [1:0]        w_win;
    logic              w_sel_hi;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic [2:0]        w_sel_memop;

    rr_arb2 u_arb (
        .i_req         ({m1_req, m0_req}),
        .i_last_winner (r_last_winner),
        .i_mode        (L_MODE),
        .o_winner      (w_win)
    );

    assign w_sel_hi    = w_win[1];
    assign w_sel_we    = w_sel_hi ? m1_we    : m0_we;
    assign w_sel_addr  = w_sel_hi ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_sel_hi ? m1_wdata : m0_wdata;
    assign w_sel_memop = w_sel_hi ? m1_memop : m0_memop;

    // Sequencing FSM with all outputs registered; pulses default low each cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_gnt         <= 2'b00;
            r_rvalid      <= 2'b00;
            r_wack        <= 2'b00;
            r_rdata0      <= 32'h0000_0000;
            r_rdata1      <= 32'h0000_0000;
            r_busy        <= 1'b0;
            r_addr        <= '0;
            r_datain      <= 32'h0000_0000;
            r_memop       <= 3'b000;
            r_we          <= 1'b0;
            r_rdclk       <= 1'b0;
            r_wrclk       <= 1'b0;
            r_last_winner <= 1'b1;
            r_winner      <= 1'b0;
        end else begin
            r_gnt    <= 2'b00;
            r_rvalid <= 2'b00;
            r_wack   <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_win != 2'b00) begin
                        r_winner      <= w_sel_hi;
                        r_last_winner <= w_sel_hi;
                        r_addr        <= w_sel_addr;
                        r_datain      <= w_sel_wdata;
                        r_memop       <= w_sel_memop;
                        r_we          <= w_sel_we;
                        r_gnt         <= w_win;
                        r_rdclk       <= 1'b1;
                        r_wrclk       <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= ACCESS;
                    end else begin
                        r_rdclk <= 1'b0;
                        r_wrclk <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                ACCESS: begin
                    r_rdclk <= 1'b0;
                    if (r_we) begin
                        // Old word has been read; now strobe the merged write
                        r_wrclk <= 1'b1;
                        r_state <= WRITE;
                    end else begin
                        r_rvalid <= idx_to_onehot(r_winner);
                        if (r_winner) begin
                            r_rdata1 <= dmem_dataout;
                        end else begin
                            r_rdata0 <= dmem_dataout;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= IDLE;
                end
                WRITE: begin
                    r_wrclk <= 1'b0;
                    r_wack  <= idx_to_onehot(r_winner);
                    r_state <= DONE;
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_rdclk <= 1'b0;
                    r_wrclk <= 1'b0;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m0_gnt      = r_gnt[0];
    assign m1_gnt      = r_gnt[1];
    assign m0_rvalid   = r_rvalid[0];
    assign m1_rvalid   = r_rvalid[1];
    assign m0_wack     = r_wack[0];
    assign m1_wack     = r_wack[1];
    assign m0_rdata    = r_rdata0;
    assign m1_rdata    = r_rdata1;
    assign busy        = r_busy;
    assign dmem_addr   = r_addr;
    assign dmem_datain = r_datain;
    assign dmem_memop  = r_memop;
    assign dmem_we     = r_we;
    assign dmem_rdclk  = r_rdclk;
    assign dmem_wrclk  = r_wrclk;

endmodule

// File: tb/tb_dmem_sched.sv
// Directed bench for dmem_sched: round-robin instance with a byte-enable
// memory model, plus a fixed-priority instance sharing the same requests.
module tb_dmem_sched;

    logic        clock;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_memop, m1_memop;

    logic        rr_m0_gnt, rr_m0_rvalid, rr_m0_wack, rr_m1_gnt, rr_m1_rvalid, rr_m1_wack;
    logic [31:0] rr_m0_rdata, rr_m1_rdata;
    logic        rr_busy, rr_we, rr_rdclk, rr_wrclk;
    logic [31:0] rr_addr, rr_datain, rr_dataout;
    logic [2:0]  rr_memop;

    logic        fx_m0_gnt, fx_m0_rvalid, fx_m0_wack, fx_m1_gnt, fx_m1_rvalid, fx_m1_wack;
    logic [31:0] fx_m0_rdata, fx_m1_rdata;
    logic        fx_busy, fx_we, fx_rdclk, fx_wrclk;
    logic [31:0] fx_addr, fx_datain;
    logic [2:0]  fx_memop;

    logic [31:0] mem [0:255];
    logic [31:0] old_w, new_w;

    int checks = 0;
    int errs   = 0;

    dmem_sched #(.ARB_MODE(0), .ADDR_W(32)) dut_rr (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_memop(m0_memop),
        .m0_gnt(rr_m0_gnt), .m0_rvalid(rr_m0_rvalid), .m0_rdata(rr_m0_rdata), .m0_wack(rr_m0_wack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_memop(m1_memop),
        .m1_gnt(rr_m1_gnt), .m1_rvalid(rr_m1_rvalid), .m1_rdata(rr_m1_rdata), .m1_wack(rr_m1_wack),
        .busy(rr_busy), .dmem_addr(rr_addr), .dmem_datain(rr_datain), .dmem_memop(rr_memop),
        .dmem_we(rr_we), .dmem_rdclk(rr_rdclk), .dmem_wrclk(rr_wrclk), .dmem_dataout(rr_dataout)
    );

    dmem_sched #(.ARB_MODE(1), .ADDR_W(32)) dut_fx (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_memop(m0_memop),
        .m0_gnt(fx_m0_gnt), .m0_rvalid(fx_m0_rvalid), .m0_rdata(fx_m0_rdata), .m0_wack(fx_m0_wack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_memop(m1_memop),
        .m1_gnt(fx_m1_gnt), .m1_rvalid(fx_m1_rvalid), .m1_rdata(fx_m1_rdata), .m1_wack(fx_m1_wack),
        .busy(fx_busy), .dmem_addr(fx_addr), .dmem_datain(fx_datain), .dmem_memop(fx_memop),
        .dmem_we(fx_we), .dmem_rdclk(fx_rdclk), .dmem_wrclk(fx_wrclk), .dmem_dataout(32'h0000_0000)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Load result of the memory model: extract and extend per memop
    function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [1:0] a, input logic [2:0] op);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {a, 3'b000};
        b  = sh[7:0];
        h  = a[1] ? w[31:16] : w[15:0];
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return w;
            3'b100:  return {24'h000000, b};
            3'b101:  return {16'h0000, h};
            default: return w;
        endcase
    endfunction

    assign rr_dataout = ld_ext(mem[rr_addr[9:2]], rr_addr[1:0], rr_memop);

    // Byte-enable write on the write strobe; undefined memops leave memory unchanged
    always @(posedge rr_wrclk) begin
        old_w = mem[rr_addr[9:2]];
        new_w = old_w;
        case (rr_memop)
            3'b000: begin
                case (rr_addr[1:0])
                    2'd0:    new_w[7:0]   = rr_datain[7:0];
                    2'd1:    new_w[15:8]  = rr_datain[7:0];
                    2'd2:    new_w[23:16] = rr_datain[7:0];
                    default: new_w[31:24] = rr_datain[7:0];
                endcase
            end
            3'b001: begin
                if (rr_addr[1]) new_w[31:16] = rr_datain[15:0];
                else            new_w[15:0]  = rr_datain[15:0];
            end
            3'b010:  new_w = rr_datain;
            default: new_w = old_w;
        endcase
        mem[rr_addr[9:2]] = new_w;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Read and write strobes must never overlap
    always @(negedge clock) begin
        if (reset) check_eq("strobe_excl", {31'b0, rr_rdclk & rr_wrclk}, 32'h0000_0000);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] op);
        if (p == 1) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_memop = op;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_memop = op;
        end
    endtask

    task automatic clr_req(input int p);
        if (p == 1) m1_req = 1'b0;
        else        m0_req = 1'b0;
    endtask

    // One transaction on port p with cycle-exact checks, starting from an IDLE sample point
    task automatic xact(input string tag, input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] op, input logic [31:0] exp_rd);
        set_req(p, we, addr, wdata, op);
        tick();
        check_eq({tag, ".gnt"}, {30'b0, rr_m1_gnt, rr_m0_gnt}, (p == 1) ? 32'd2 : 32'd1);
        check_eq({tag, ".rdclk"}, {31'b0, rr_rdclk}, 32'd1);
        check_eq({tag, ".addr"}, rr_addr, addr);
        check_eq({tag, ".we"}, {31'b0, rr_we}, {31'b0, we});
        clr_req(p);
        tick();
        if (!we) begin
            check_eq({tag, ".rvalid"}, {30'b0, rr_m1_rvalid, rr_m0_rvalid}, (p == 1) ? 32'd2 : 32'd1);
            check_eq({tag, ".rdata"}, (p == 1) ? rr_m1_rdata : rr_m0_rdata, exp_rd);
            check_eq({tag, ".rdclk_off"}, {31'b0, rr_rdclk}, 32'd0);
            tick();
            check_eq({tag, ".done"}, {29'b0, rr_busy, rr_m1_rvalid, rr_m0_rvalid}, 32'd0);
            check_eq({tag, ".hold"}, (p == 1) ? rr_m1_rdata : rr_m0_rdata, exp_rd);
        end else begin
            check_eq({tag, ".wrclk"}, {30'b0, rr_rdclk, rr_wrclk}, 32'd1);
            check_eq({tag, ".datain"}, rr_datain, wdata);
            check_eq({tag, ".we_hold"}, {31'b0, rr_we}, 32'd1);
            tick();
            check_eq({tag, ".wack"}, {30'b0, rr_m1_wack, rr_m0_wack}, (p == 1) ? 32'd2 : 32'd1);
            check_eq({tag, ".wr_end"}, {30'b0, rr_busy, rr_wrclk}, 32'd2);
            tick();
            check_eq({tag, ".idle"}, {28'b0, rr_busy, rr_we, rr_m1_wack, rr_m0_wack}, 32'd0);
            check_eq({tag, ".addr_kept"}, rr_addr, addr);
        end
    endtask

    initial begin
        reset = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_memop = 3'b000;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_memop = 3'b000;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
        mem[8'h00] = 32'h8000_FF80;
        mem[8'h40] = 32'hDEAD_BEEF;
        mem[8'h41] = 32'h0BAD_F00D;

        // Reset held three cycles: everything low
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst.ctl", {22'b0, rr_m0_gnt, rr_m1_gnt, rr_m0_rvalid, rr_m1_rvalid, rr_m0_wack,
                             rr_m1_wack, rr_busy, rr_we, rr_rdclk, rr_wrclk}, 32'd0);
        check_eq("rst.rdata", rr_m0_rdata | rr_m1_rdata, 32'd0);
        check_eq("rst.addr", rr_addr, 32'd0);
        check_eq("rst.datain", rr_datain, 32'd0);
        check_eq("rst.memop", {29'b0, rr_memop}, 32'd0);
        check_eq("rst.fx", {29'b0, fx_busy, fx_rdclk, fx_wrclk}, 32'd0);
        reset = 1'b1;

        // First request right after release, then basic loads
        xact("t1_lw0", 0, 1'b0, 32'h0000_0000, 32'h0, 3'b010, 32'h8000_FF80);
        xact("t2_lw", 0, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 32'hDEAD_BEEF);
        xact("t5_lh", 0, 1'b0, 32'h0000_0002, 32'h0, 3'b001, 32'hFFFF_8000);
        xact("t5_lbu", 0, 1'b0, 32'h0000_0000, 32'h0, 3'b100, 32'h0000_0080);
        xact("t5_lb", 0, 1'b0, 32'h0000_0000, 32'h0, 3'b000, 32'hFFFF_FF80);

        // Byte store then read back the merged word on m1; m0 hold reg untouched
        mem[8'h40] = 32'h1122_3344;
        xact("t3_sb", 1, 1'b1, 32'h0000_0101, 32'h0000_00AB, 3'b000, 32'h0);
        xact("t3_lw", 1, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 32'h1122_AB44);
        check_eq("t3_m0hold", rr_m0_rdata, 32'hFFFF_FF80);

        // Undefined store memop: full sequence, memory unchanged
        xact("oor_st", 0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 3'b011, 32'h0);
        xact("oor_lw", 1, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 32'h1122_AB44);

        // Both requesting continuously: rr alternates from m0, fixed always m0
        set_req(0, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
        set_req(1, 1'b0, 32'h0000_0104, 32'h0, 3'b010);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t4_rr_gnt", {30'b0, rr_m1_gnt, rr_m0_gnt}, (i % 2 == 1) ? 32'd2 : 32'd1);
            check_eq("t4_fx_gnt", {30'b0, fx_m1_gnt, fx_m0_gnt}, 32'd1);
            if (i == 3) begin
                clr_req(0);
                clr_req(1);
            end
            tick();
            tick();
        end
        check_eq("t4_idle", {30'b0, rr_busy, fx_busy}, 32'd0);
        check_eq("t4_m1data", rr_m1_rdata, 32'h0BAD_F00D);

        // Reset during WRITE: strobe drops at once, no wack, then normal load
        set_req(0, 1'b1, 32'h0000_0200, 32'h0000_0055, 3'b010);
        tick();
        check_eq("t6_gnt", {31'b0, rr_m0_gnt}, 32'd1);
        clr_req(0);
        tick();
        check_eq("t6_wrclk", {31'b0, rr_wrclk}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_async", {29'b0, rr_wrclk, rr_busy, rr_we}, 32'd0);
        tick();
        check_eq("t6_nowack", {30'b0, rr_m1_wack, rr_m0_wack}, 32'd0);
        check_eq("t6_rdata_clr", rr_m0_rdata, 32'd0);
        reset = 1'b1;
        xact("t6_lw", 0, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 32'h1122_AB44);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
